// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet transmit path.
//   tx_state_t       : transmit scheduler state encoding
//   C_MIN_FRAME_LEN  : minimum bytes sent ahead of the FCS
//   sat_inc11()      : saturating increment for the 11-bit byte counter
package eth_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SOF  = 3'd1,
    S_DATA = 3'd2,
    S_PAD  = 3'd3,
    S_EOF  = 3'd4
  } tx_state_t;

  localparam int          C_MIN_FRAME_LEN = 60;
  localparam logic [10:0] C_BYTE_CNT_MAX  = 11'd2047;

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == C_BYTE_CNT_MAX) ? v : (v + 11'd1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a frame-granular pointer.
//   clk, rst : clock, synchronous active-high reset
//   req      : request vector
//   load     : move the pointer to the index currently granted
//   grant    : one-hot grant of the first requester after the pointer
//   any_req  : at least one request is present
// The pointer resets to N-1 so requester 0 has priority first.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         load,
  output logic [N-1:0] grant,
  output logic         any_req
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr_r;
  logic [IW-1:0] idx_s;
  int            best_s;
  int            dist_s;
  logic          take_s;

  // Pick the requester with the smallest cyclic distance past the pointer.
  always_comb begin
    idx_s  = ptr_r;
    best_s = N;
    dist_s = 0;
    take_s = 1'b0;
    for (int j = 0; j < N; j++) begin
      dist_s = (j + 2 * N - 1 - int'(ptr_r)) % N;
      take_s = req[j] && (dist_s < best_s);
      best_s = take_s ? dist_s : best_s;
      idx_s  = take_s ? IW'(j) : idx_s;
    end
  end

  assign any_req = |req;
  assign grant   = any_req ? ({{(N-1){1'b0}}, 1'b1} << idx_s) : {N{1'b0}};

  // Pointer update: only on load, so it tracks the last completed frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= IW'(N - 1);
    end else if (load && any_req) begin
      ptr_r <= idx_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/eth_tx_sched.sv
// Transmit frame scheduler in front of mii_tx.
//   tx_clk, tx_rst          : MAC transmit clock, synchronous active-high reset
//   req_valid/req_grant     : per-requester frame request and one-hot grant
//   req_byte/_vld/_last     : byte stream of each requester
//   req_byte_rdy            : byte taken from the granted requester
//   tx_sof/tx_sof_ack       : start-of-frame handshake with the MAC
//   tx_byte/_vld/_rdy       : byte to MAC; MAC takes lo nibble on rdy, hi nibble next cycle
//   tx_eof                  : end of frame, on the MAC's next lo cycle after the last hi nibble
//   tx_underrun             : a requester byte was missing and 0x00 was sent instead
//   tx_busy                 : scheduler is not idle
// Frames shorter than MIN_LEN are zero-padded up to MIN_LEN bytes.
module eth_tx_sched
  import eth_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int MIN_LEN = C_MIN_FRAME_LEN
) (
  input  logic               tx_clk,
  input  logic               tx_rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_grant,
  input  logic [8*N_REQ-1:0] req_byte,
  input  logic [N_REQ-1:0]   req_byte_vld,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_byte_rdy,
  output logic               tx_sof,
  input  logic               tx_sof_ack,
  output logic [7:0]         tx_byte,
  output logic               tx_byte_vld,
  input  logic               tx_byte_rdy,
  output logic               tx_eof,
  output logic               tx_underrun,
  output logic               tx_busy
);

  localparam logic [10:0] MIN_LEN_C = 11'(MIN_LEN);

  tx_state_t        state_r;
  logic [N_REQ-1:0] grant_r;
  logic [7:0]       byte_r;
  logic             last_flag_r;
  logic             byte_full_r;   // first byte of the frame has been loaded
  logic             hi_phase_r;    // MAC is sampling the high nibble this cycle
  logic             sof_r;
  logic             eof_r;
  logic             underrun_r;
  logic [10:0]      byte_cnt_r;

  logic [N_REQ-1:0] arb_req_s;
  logic [N_REQ-1:0] arb_grant_s;
  logic             arb_load_s;
  logic             arb_any_s;
  logic [7:0]       cur_byte_s;
  logic             cur_vld_s;
  logic             cur_last_s;
  logic             rdy_s;

  // At end of frame the arbiter sees only the granted line, so load moves the
  // pointer onto the requester that just finished.
  assign arb_load_s = (state_r == S_EOF);
  assign arb_req_s  = arb_load_s ? grant_r : req_valid;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk     (tx_clk),
    .rst     (tx_rst),
    .req     (arb_req_s),
    .load    (arb_load_s),
    .grant   (arb_grant_s),
    .any_req (arb_any_s)
  );

  // One-hot AND-OR mux of the granted requester's byte stream.
  always_comb begin
    cur_byte_s = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      cur_byte_s = cur_byte_s | (req_byte[8*i +: 8] & {8{grant_r[i]}});
    end
    cur_vld_s  = |(req_byte_vld & grant_r);
    cur_last_s = |(req_last & grant_r);
  end

  // Byte take decision: prefetch into an empty buffer (never on a lo-nibble
  // cycle), otherwise refill on the hi-nibble cycle until the last byte.
  always_comb begin
    rdy_s = 1'b0;
    case (state_r)
      S_SOF:   rdy_s = cur_vld_s & ~byte_full_r;
      S_DATA:  rdy_s = hi_phase_r ? (cur_vld_s & ~last_flag_r)
                                  : (cur_vld_s & ~byte_full_r & ~tx_byte_rdy);
      default: rdy_s = 1'b0;
    endcase
  end

  assign req_byte_rdy = {N_REQ{rdy_s}} & grant_r;
  assign req_grant    = grant_r;
  assign tx_sof       = sof_r;
  assign tx_byte      = byte_r;
  assign tx_eof       = eof_r;
  assign tx_underrun  = underrun_r;
  assign tx_byte_vld  = (state_r == S_DATA) || (state_r == S_PAD);
  assign tx_busy      = (state_r != S_IDLE);

  // Scheduler FSM and datapath registers.
  always_ff @(posedge tx_clk) begin
    if (tx_rst) begin
      state_r     <= S_IDLE;
      grant_r     <= {N_REQ{1'b0}};
      byte_r      <= 8'h00;
      last_flag_r <= 1'b0;
      byte_full_r <= 1'b0;
      hi_phase_r  <= 1'b0;
      sof_r       <= 1'b0;
      eof_r       <= 1'b0;
      underrun_r  <= 1'b0;
      byte_cnt_r  <= 11'd0;
    end else begin
      eof_r      <= 1'b0;
      underrun_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (arb_any_s) begin
            grant_r <= arb_grant_s;
            sof_r   <= 1'b1;
            state_r <= S_SOF;
          end
        end
        S_SOF: begin
          if (rdy_s) begin
            byte_r      <= cur_byte_s;
            last_flag_r <= cur_last_s;
            byte_full_r <= 1'b1;
          end
          if (tx_sof_ack) begin
            sof_r   <= 1'b0;
            state_r <= S_DATA;
          end
        end
        S_DATA: begin
          if (hi_phase_r) begin
            hi_phase_r <= 1'b0;
            if (!last_flag_r) begin
              if (rdy_s) begin
                byte_r      <= cur_byte_s;
                last_flag_r <= cur_last_s;
              end else begin
                byte_r     <= 8'h00;
                underrun_r <= 1'b1;
              end
            end else if (byte_cnt_r < MIN_LEN_C) begin
              byte_r  <= 8'h00;
              state_r <= S_PAD;
            end else begin
              // eof lands on the MAC's next lo cycle, after the hi nibble
              eof_r   <= 1'b1;
              state_r <= S_EOF;
            end
          end else if (tx_byte_rdy) begin
            byte_cnt_r <= sat_inc11(byte_cnt_r);
            hi_phase_r <= 1'b1;
            if (!byte_full_r) begin
              // first byte never arrived: byte_r is still 0x00
              underrun_r  <= 1'b1;
              byte_full_r <= 1'b1;
              last_flag_r <= 1'b0;
            end
          end else if (rdy_s) begin
            byte_r      <= cur_byte_s;
            last_flag_r <= cur_last_s;
            byte_full_r <= 1'b1;
          end
        end
        S_PAD: begin
          if (hi_phase_r) begin
            hi_phase_r <= 1'b0;
            if (byte_cnt_r >= MIN_LEN_C) begin
              eof_r   <= 1'b1;
              state_r <= S_EOF;
            end
          end else if (tx_byte_rdy) begin
            byte_cnt_r <= sat_inc11(byte_cnt_r);
            hi_phase_r <= 1'b1;
          end
        end
        S_EOF: begin
          grant_r     <= {N_REQ{1'b0}};
          byte_cnt_r  <= 11'd0;
          byte_full_r <= 1'b0;
          last_flag_r <= 1'b0;
          hi_phase_r  <= 1'b0;
          byte_r      <= 8'h00;
          state_r     <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_sched.sv
// Directed bench for eth_tx_sched: bench-side requester and MAC models,
// linear stimulus, immediate-assertion checks.
module tb_eth_tx_sched;

  logic        tx_clk;
  logic        tx_rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_grant;
  logic [23:0] req_byte;
  logic [2:0]  req_byte_vld;
  logic [2:0]  req_last;
  logic [2:0]  req_byte_rdy;
  logic        tx_sof;
  logic        tx_sof_ack;
  logic [7:0]  tx_byte;
  logic        tx_byte_vld;
  logic        tx_byte_rdy;
  logic        tx_eof;
  logic        tx_underrun;
  logic        tx_busy;

  eth_tx_sched #(.N_REQ(3), .MIN_LEN(60)) dut (
    .tx_clk       (tx_clk),
    .tx_rst       (tx_rst),
    .req_valid    (req_valid),
    .req_grant    (req_grant),
    .req_byte     (req_byte),
    .req_byte_vld (req_byte_vld),
    .req_last     (req_last),
    .req_byte_rdy (req_byte_rdy),
    .tx_sof       (tx_sof),
    .tx_sof_ack   (tx_sof_ack),
    .tx_byte      (tx_byte),
    .tx_byte_vld  (tx_byte_vld),
    .tx_byte_rdy  (tx_byte_rdy),
    .tx_eof       (tx_eof),
    .tx_underrun  (tx_underrun),
    .tx_busy      (tx_busy)
  );

  initial tx_clk = 1'b0;
  always #5 tx_clk = ~tx_clk;

  int vectors;
  int miscompares;

  // requester models
  int         rq_len[3];
  int         rq_k[3];
  int         rq_stall_at[3];
  int         rq_stall_cnt[3];
  bit         rq_pend[3];
  logic [7:0] rq_base[3];

  // MAC model and observations
  int         cyc;
  bit         mac_ack_due;
  bit         mac_run;
  int         mac_wait;
  bit         mac_hi;
  logic [7:0] cap [0:255];
  int         ncap;
  int         eof_cnt;
  int         eof_gap;
  int         last_rdy_cyc;
  int         und_cnt;
  int         rdy_cnt;
  int         glog[$];
  logic [2:0] prev_grant;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_models();
    for (int i = 0; i < 3; i++) begin
      rq_len[i] = 0; rq_k[i] = 0; rq_stall_at[i] = -1;
      rq_stall_cnt[i] = 0; rq_pend[i] = 1'b0; rq_base[i] = 8'h00;
    end
    mac_ack_due = 1'b0; mac_run = 1'b0; mac_wait = 0; mac_hi = 1'b0;
    prev_grant = 3'b000;
  endtask

  task automatic clear_stats();
    ncap = 0; eof_cnt = 0; eof_gap = 0; und_cnt = 0; rdy_cnt = 0;
    exp_q.delete();
  endtask

  task automatic arm(input int i, input int len, input logic [7:0] base, input int stall_at);
    rq_len[i] = len; rq_k[i] = 0; rq_base[i] = base;
    rq_stall_at[i] = stall_at; rq_stall_cnt[i] = 0; rq_pend[i] = 1'b1;
  endtask

  // One clock: observe at the falling edge, drive inputs, settle, sample req_byte_rdy.
  task automatic step();
    logic vld;
    @(negedge tx_clk);
    cyc++;
    if (tx_eof) begin
      eof_cnt++;
      eof_gap = cyc - last_rdy_cyc;
      mac_run = 1'b0;
    end
    if (tx_underrun) und_cnt++;
    if (mac_hi) begin
      if (ncap < 256) cap[ncap][7:4] = tx_byte[7:4];
      ncap++;
      mac_hi = 1'b0;
    end
    tx_sof_ack  = 1'b0;
    tx_byte_rdy = 1'b0;
    if (mac_ack_due) begin
      tx_sof_ack  = 1'b1;
      mac_ack_due = 1'b0;
      mac_run     = 1'b1;
      mac_wait    = 1;
    end else if (tx_sof) begin
      mac_ack_due = 1'b1;
    end else if (mac_run) begin
      if (mac_wait > 0) begin
        mac_wait--;
      end else begin
        tx_byte_rdy = 1'b1;
        mac_wait    = 1;
        if (tx_byte_vld) begin
          if (ncap < 256) cap[ncap][3:0] = tx_byte[3:0];
          mac_hi       = 1'b1;
          last_rdy_cyc = cyc;
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = rq_pend[i];
      vld = (rq_k[i] < rq_len[i]);
      if (rq_stall_cnt[i] > 0) begin
        vld = 1'b0;
        rq_stall_cnt[i]--;
      end
      req_byte_vld[i]    = vld;
      req_byte[8*i +: 8] = rq_base[i] + 8'(rq_k[i]);
      req_last[i]        = (rq_k[i] == rq_len[i] - 1);
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      if (req_byte_rdy[i]) begin
        rdy_cnt++;
        rq_k[i]++;
        if (rq_k[i] == rq_stall_at[i]) rq_stall_cnt[i] = 4;
      end
      if (req_grant[i] && !prev_grant[i]) glog.push_back(i);
      if (req_grant[i]) rq_pend[i] = 1'b0;
    end
    prev_grant = req_grant;
  endtask

  task automatic run_eofs(input string tag, input int n, input int bound);
    int b;
    b = 0;
    while (eof_cnt < n && b < bound) begin
      step();
      b++;
    end
    chk({tag, "_eof_count"}, eof_cnt, n);
  endtask

  task automatic push_frame(input logic [7:0] base, input int len);
    for (int i = 0; i < 60; i++) exp_q.push_back((i < len) ? base + 8'(i) : 8'h00);
    for (int i = 60; i < len; i++) exp_q.push_back(base + 8'(i));
  endtask

  task automatic check_data(input string tag);
    int err;
    err = 0;
    chk({tag, "_bytes"}, ncap, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < 256; i++) begin
      if (cap[i] !== exp_q[i]) err++;
    end
    chk({tag, "_data_err"}, err, 0);
  endtask

  initial begin
    logic [18:0] outs;
    vectors = 0; miscompares = 0; cyc = 0; last_rdy_cyc = 0;
    tx_rst = 1'b1; req_valid = 3'b000; req_byte = 24'h000000;
    req_byte_vld = 3'b000; req_last = 3'b000; tx_sof_ack = 1'b0; tx_byte_rdy = 1'b0;
    reset_models();
    clear_stats();

    // reset state
    step(); step();
    tx_rst = 1'b0;
    step();
    outs = {req_grant, req_byte_rdy, tx_sof, tx_byte, tx_byte_vld, tx_eof, tx_underrun, tx_busy};
    chk("reset_outputs", int'(outs), 0);

    // req0: 64-byte frame 0x00..0x3F
    clear_stats();
    arm(0, 64, 8'h00, -1);
    step();
    step();
    chk("f64_grant", int'(req_grant), 1);
    chk("f64_sof", int'(tx_sof), 1);
    run_eofs("f64", 1, 400);
    push_frame(8'h00, 64);
    check_data("f64");
    chk("f64_rdy_pulses", rdy_cnt, 64);
    chk("f64_eof_gap", eof_gap, 2);
    chk("f64_underrun", und_cnt, 0);
    chk("f64_last_byte", int'(cap[63]), 8'h3F);
    step();
    chk("f64_idle_after", int'({req_grant, tx_busy, tx_eof}), 0);

    // req1: 10-byte frame, padded to 60
    clear_stats();
    arm(1, 10, 8'hA0, -1);
    step();
    step();
    chk("f10_grant", int'(req_grant), 2);
    run_eofs("f10", 1, 400);
    push_frame(8'hA0, 10);
    check_data("f10");
    chk("f10_rdy_pulses", rdy_cnt, 10);
    chk("f10_eof_gap", eof_gap, 2);
    chk("f10_underrun", und_cnt, 0);

    // req2: 64-byte frame with a 4-cycle stall after byte 19
    clear_stats();
    arm(2, 64, 8'h40, 20);
    run_eofs("stall", 1, 400);
    for (int i = 0; i < 66; i++) begin
      if (i < 20) exp_q.push_back(8'h40 + 8'(i));
      else if (i < 22) exp_q.push_back(8'h00);
      else exp_q.push_back(8'h40 + 8'(i - 2));
    end
    check_data("stall");
    chk("stall_underruns", und_cnt, 2);
    chk("stall_rdy_pulses", rdy_cnt, 64);
    chk("stall_eof_gap", eof_gap, 2);

    // reset, then all three request together
    tx_rst = 1'b1;
    step();
    tx_rst = 1'b0;
    reset_models();
    clear_stats();
    glog.delete();
    step();
    arm(0, 4, 8'h10, -1);
    arm(1, 4, 8'h20, -1);
    arm(2, 4, 8'h30, -1);
    run_eofs("rr3", 3, 1200);
    push_frame(8'h10, 4);
    push_frame(8'h20, 4);
    push_frame(8'h30, 4);
    check_data("rr3");
    chk("rr3_eof_gap", eof_gap, 2);
    step();
    arm(0, 4, 8'h11, -1);
    arm(2, 4, 8'h33, -1);
    run_eofs("rr5", 5, 1200);
    chk("rr_grant_count", glog.size(), 5);
    if (glog.size() == 5) begin
      chk("rr_grant_1st", glog[0], 0);
      chk("rr_grant_2nd", glog[1], 1);
      chk("rr_grant_3rd", glog[2], 2);
      chk("rr_grant_4th", glog[3], 0);
      chk("rr_grant_5th", glog[4], 2);
    end

    // reset in the middle of a frame from req1
    step();
    clear_stats();
    arm(1, 64, 8'h80, -1);
    begin
      int b;
      b = 0;
      while (ncap < 20 && b < 400) begin
        step();
        b++;
      end
    end
    chk("midrst_reached_byte20", int'(ncap >= 20), 1);
    tx_rst = 1'b1;
    step();
    tx_rst = 1'b0;
    reset_models();
    step();
    outs = {req_grant, req_byte_rdy, tx_sof, tx_byte, tx_byte_vld, tx_eof, tx_underrun, tx_busy};
    chk("midrst_outputs", int'(outs), 0);

    // clean frame from req2 afterwards
    clear_stats();
    arm(2, 5, 8'h50, -1);
    step();
    step();
    chk("post_rst_grant", int'(req_grant), 4);
    chk("post_rst_sof", int'(tx_sof), 1);
    run_eofs("post_rst", 1, 400);
    push_frame(8'h50, 5);
    check_data("post_rst");
    chk("post_rst_eof_gap", eof_gap, 2);
    chk("post_rst_underrun", und_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/eth_tx_sched.md
# eth_tx_sched

Transmit frame scheduler that shares the `mii_tx` byte port among `N_REQ` frame sources (e.g. ARP, ICMP, UDP engines). It arbitrates round-robin at frame granularity and drives the start-of-frame handshake. It meters bytes to the MAC at its fixed two-cycle-per-byte rate, pads short frames to `MIN_LEN`, and places `tx_eof` on the exact cycle `mii_tx` requires. It sits directly between the protocol engines and `mii_tx`, in the `tx_clk` domain.

## Interface
- `N_REQ`, default 3: number of requesters, 2–8.
- `MIN_LEN`, default 60: minimum bytes sent before the FCS; shorter frames are zero-padded.

- `tx_clk`  in  1  MAC transmit clock.
- `tx_rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `req_valid`  in  N_REQ  requester i has a frame pending; held high until granted.
- `req_grant`  out  N_REQ  one-hot; held for the whole frame.
- `req_byte`  in  8·N_REQ  requester i byte at bits [8i+7:8i].
- `req_byte_vld`  in  N_REQ  byte valid.
- `req_last`  in  N_REQ  qualifies `req_byte` as the final frame byte.
- `req_byte_rdy`  out  N_REQ  one-cycle pulse; byte consumed from the granted requester.
- `tx_sof`  out  1  to MAC; held until `tx_sof_ack`.
- `tx_sof_ack`  in  1  from MAC.
- `tx_byte`  out  8  to MAC.
- `tx_byte_vld`  out  1  high while a byte is presented.
- `tx_byte_rdy`  in  1  MAC has sampled the low nibble of `tx_byte`.
- `tx_eof`  out  1  one-cycle pulse to MAC.
- `tx_underrun`  out  1  one-cycle pulse; a requester byte was not ready when needed.
- `tx_busy`  out  1  high in any state other than S_IDLE.

## Operation
- The MAC does not stall. While sending, it samples `tx_byte[3:0]` on the `tx_byte_rdy` cycle t and `tx_byte[7:4]` on t+1. The next `tx_byte_rdy` comes at t+2.
- **S_IDLE:**
  - If any `req_valid` is set, grant the first index after `last_ptr`, searching cyclically.
  - Assert `req_grant` and `tx_sof`, and go to S_SOF.
- **S_SOF:**
  - Prefetch the first byte: when `req_byte_vld` is high and the byte buffer is empty, pulse `req_byte_rdy` and load `tx_byte`, `last_flag`.
  - When `tx_sof_ack` is seen, clear `tx_sof` and go to S_DATA.
  - If the first byte is not loaded when the first `tx_byte_rdy` arrives, send `0x00` and pulse `tx_underrun`.
- **S_DATA:**
  - `tx_byte_vld` is 1.
  - On a `tx_byte_rdy` cycle t, increment `byte_cnt` (11 bits, saturating at 2047) and set `hi_phase`.
  - On t+1, if `last_flag` is 0:
    - If `req_byte_vld` is high, pulse `req_byte_rdy` and load `tx_byte` and `last_flag` at the end of t+1.
    - Otherwise load `0x00` and pulse `tx_underrun`.
  - On t+1, if `last_flag` is 1:
    - If `byte_cnt` < `MIN_LEN`, go to S_PAD with `tx_byte` = 0.
    - Otherwise assert `tx_eof` (visible at t+2) and go to S_EOF.
- **S_PAD:**
  - Present `0x00`; count `tx_byte_rdy`.
  - On the hi cycle after the accept that makes `byte_cnt` == `MIN_LEN`, assert `tx_eof` and go to S_EOF.
- **S_EOF:**
  - `tx_eof` is high for exactly one cycle.
  - Drop `req_grant`, set `last_ptr` to the granted index, clear `byte_cnt`, return to S_IDLE.
- The MAC's CRC and IFG gap is absorbed automatically, because `tx_sof` is held until acknowledged.
- Requests are never preempted. `req_valid` deasserting while granted is ignored until the frame's `req_last`.

## Timing
- Reset: all outputs are 0 and `last_ptr` = N_REQ−1, so requester 0 wins first. Reset mid-frame abandons the frame; `mii_tx` is reset by the same reset.
- Grant latency: 1 cycle from `req_valid` to `req_grant` and `tx_sof`.
- `tx_eof` is asserted exactly 2 cycles after the `tx_byte_rdy` of the final byte, i.e. on the MAC's next LO cycle. Asserting it 1 cycle after would truncate the high nibble and is a bug.
- `tx_byte` is stable from load until the end of the hi-nibble cycle.
- `req_byte_rdy` pulses at most once per 2 cycles.
- A requester must answer within 1 cycle of need to avoid underrun.
- Simultaneous requests: round-robin; no requester waits more than N_REQ−1 frames.
- `req_last` on a byte that arrives during padding is impossible by construction: padding starts only after `last_flag`.

## Structure
- Shared package `eth_pkg`:
  - State enum `S_IDLE`/`S_SOF`/`S_DATA`/`S_PAD`/`S_EOF`.
  - `C_MIN_FRAME_LEN` = 60.
- One sub-module, `rr_arbiter`, parameterised by N: round-robin pointer and one-hot grant from a request vector, plus a `load` strobe.

## Test plan
- req0 sends a 64-byte frame 0x00..0x3F; the bench MAC model acks 1 cycle after `tx_sof`.
  - Exactly 64 `req_byte_rdy` pulses and nibbles in order.
  - `tx_eof` 2 cycles after the 64th `tx_byte_rdy`.
  - `tx_underrun` never asserted.
- req1 sends a 10-byte frame → 10 data bytes followed by 50 `0x00` bytes, then `tx_eof`.
- req0, req1 and req2 are all asserted at once after reset → frames are granted in order 0, 1, 2.
  - req0 is then re-asserted together with req2 → the next grant goes to req0.
- `req_byte_vld` is dropped for 4 cycles mid-frame → `0x00` is substituted, `tx_underrun` pulses, and the frame still ends with correct `tx_eof` timing.
- `tx_rst` is asserted at byte 20 → all outputs are 0 the next cycle.
  - The following request from req2 starts a clean frame with `tx_sof`.
